ccff_bitstream_loader: RTL
==========================

// Module: ccff_bitstream_loader
// PURPOSE
//  Upstream feeder of the configuration chain (p_ccff shift-register chains, ccff_head -> ccff_tail).
//  Accepts parallel bitstream words over a valid/ready stream and serializes them MSB-first onto ccff_head.
//  Emits one bit per prog_clk; ccff_shift_en drives the external clock-gate cell for the chain's prog_clk.
//  Stops after exactly CHAIN_LEN bits, then signals done.
// PARAMETERS
//  DATA_W     8     bitstream word width (>=2)
//  CHAIN_LEN  1024  total chain length in bits (>=1); need not be a multiple of DATA_W
//  CNT_W      $clog2(CHAIN_LEN+1)  bit-counter width (derived, do not override)
// PORTS
//  prog_clk       in   1       single clock
//  prog_reset     in   1       synchronous, active-high reset
//  start          in   1       1-cycle pulse; begins a load when IDLE or DONE
//  s_data         in   DATA_W  bitstream word, bit DATA_W-1 shifted first
//  s_valid        in   1       s_data valid
//  s_ready        out  1       word accepted when s_valid && s_ready
//  ccff_head      out  1       serial bit into chain head
//  ccff_shift_en  out  1       chain clock enable: chain captures ccff_head on this cycle's edge
//  busy           out  1       high in LOAD/SHIFT
//  done           out  1       high in DONE, held until next start
//  bit_cnt        out  CNT_W   bits shifted so far in current load
//  crc_out        out  8       CRC of shifted bits (present only with CCFF_LOADER_CRC_EN)
// BEHAVIOUR
//  Reset (and any cycle with prog_reset=1): state IDLE; s_ready=0, ccff_head=0, ccff_shift_en=0,
//   busy=0, done=0, bit_cnt=0, shift reg and bits_left cleared, crc_out=0x00. Reset mid-load aborts; no partial state kept.
//  FSM: IDLE -start-> LOAD; LOAD -word accepted-> SHIFT; SHIFT -bits_left reaches 0, no new word-> LOAD;
//   SHIFT/LOAD -bit_cnt==CHAIN_LEN-> DONE; DONE -start-> LOAD (bit_cnt, crc cleared). start while busy ignored.
//  s_ready = busy && (bit_cnt < CHAIN_LEN) && (bits_left==0 || (bits_left==1 && ccff_shift_en)).
//  Word accepted at edge t: first bit on ccff_head with ccff_shift_en=1 in cycle t+1. Back-to-back words
//   accepted on the last bit's cycle stream with zero bubbles (1 bit/cycle sustained).
//  ccff_shift_en=1 iff state SHIFT and bits_left>0; ccff_head = shift_reg[MSB] (registered, 0 when not shifting).
//  Each shifting cycle: bit_cnt+=1, bits_left-=1, shift_reg<<=1.
//  Starvation (s_valid=0 at word boundary): ccff_shift_en=0, ccff_head=0, chain holds; resume on next word.
//  Final partial word: when bit_cnt reaches CHAIN_LEN mid-word, remaining low bits discarded, s_ready=0, -> DONE
//   next cycle. No extra shift ever issued: total ccff_shift_en pulses per load == CHAIN_LEN exactly.
//  s_data/s_valid ignored outside LOAD/SHIFT; s_ready never asserted in IDLE/DONE.
// CONFIGURATION
//  CCFF_LOADER_CRC_EN defined: CRC-8, poly 0x07, init 0x00, no reflection, updated with ccff_head on every
//   ccff_shift_en cycle; crc_out valid while done=1, cleared on start. Undefined: crc_out port and logic absent.
// STRUCTURE
//  Package ccff_loader_pkg: FSM state encoding (IDLE/LOAD/SHIFT/DONE), CRC8_POLY=8'h07, CRC8_INIT=8'h00.
//  One sub-module: ccff_loader_piso (DATA_W-bit load/shift register + bits_left counter); FSM, bit_cnt, CRC in top.
// TESTING
//  1. DATA_W=8, CHAIN_LEN=16: start, words 0xA5,0x3C back-to-back -> head 1010010100111100, 16 enable pulses, no gap, done at cycle 18.
//  2. CHAIN_LEN=12: words 0xFF,0x0F -> head 11111111 0000, exactly 12 pulses, low nibble of 0x0F dropped, s_ready=0 after word 2.
//  3. Starve 3 cycles between words -> ccff_shift_en=0 and ccff_head=0 for 3 cycles, bit_cnt frozen, stream resumes intact.
//  4. prog_reset asserted at bit_cnt=5 -> next cycle all outputs 0, IDLE; new start reloads from bit_cnt=0.
//  5. start pulsed in SHIFT -> ignored; start in DONE -> done=0, bit_cnt=0, new load proceeds.
//  6. CRC_EN, CHAIN_LEN=8, word 0x01 -> crc_out=0x07 with done; scoreboard chain model: ccff_tail sequence matches shifted bits.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial step of a non-reflected CRC-8, MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Valid/ready word stream feeding the bitstream loader.
interface ccff_bitstream_loader_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_loader_piso.sv
// Parallel-load shift register with a count of bits still to be shifted out.
module ccff_loader_piso #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BL_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  output logic              msb,
  output logic [BL_W-1:0]   bits_left
);
  logic [DATA_W-1:0] sr;

  assign msb = sr[DATA_W-1];

  // Load beats shift so a word accepted on the last bit's cycle streams without a bubble.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr        <= '0;
      bits_left <= '0;
    end else if (load) begin
      sr        <= din;
      bits_left <= BL_W'(DATA_W);
    end else if (shift) begin
      sr        <= sr << 1;
      bits_left <= bits_left - 1'b1;
    end
  end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes stream words MSB-first onto the configuration chain head for exactly CHAIN_LEN bits.
// Optional CRC-8 of the shifted bits on crc_out when CCFF_LOADER_CRC_EN is defined.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                    prog_clk,
  input  logic                    prog_reset,
  input  logic                    start,
  ccff_bitstream_loader_if.slave  stream,
  output logic                    ccff_head,
  output logic                    ccff_shift_en,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        bit_cnt
`ifdef CCFF_LOADER_CRC_EN
  ,
  output logic [7:0]              crc_out
`endif
);
  localparam int unsigned BL_W = $clog2(DATA_W + 1);

  state_t          state;
  logic [BL_W-1:0] bits_left;
  logic            msb;
  logic            accept;
  logic            last_bit;

  assign ccff_shift_en = (state == ST_SHIFT) && (bits_left != '0);
  assign ccff_head     = ccff_shift_en & msb;
  assign stream.s_ready = busy && (bit_cnt < CNT_W'(CHAIN_LEN)) &&
                          ((bits_left == '0) || ((bits_left == BL_W'(1)) && ccff_shift_en));
  assign accept   = stream.s_valid && stream.s_ready;
  assign last_bit = ccff_shift_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));

  // Reaching the chain length drops whatever is left of the current word.
  ccff_loader_piso #(
    .DATA_W (DATA_W),
    .BL_W   (BL_W)
  ) u_piso (
    .clk       (prog_clk),
    .rst       (prog_reset),
    .clr       (last_bit),
    .load      (accept),
    .din       (stream.s_data),
    .shift     (ccff_shift_en),
    .msb       (msb),
    .bits_left (bits_left)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (ccff_shift_en) bit_cnt <= bit_cnt + 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (ccff_shift_en && (bits_left == BL_W'(1)) && !accept) begin
            state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CCFF_LOADER_CRC_EN
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_out <= CRC8_INIT;
    end else if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
      crc_out <= CRC8_INIT;
    end else if (ccff_shift_en) begin
      crc_out <= crc8_step(crc_out, ccff_head);
    end
  end
`endif
endmodule
